sync_fifo: RTL and testbench
============================

# sync_fifo

Parametrised single-clock FIFO, the same-domain successor to the dual-clock FIFO in the clock-domain-crossing path. It buffers bursts between producer and consumer blocks that share one clock. Beyond the dual-clock block, it adds a fill-level output, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags. A compile-time first-word-fall-through read mode is also available.

## Interface
- DATA_WIDTH, 8, word width in bits
- DEPTH, 8, number of entries; power of two, ≥ 2
- ALMOST_FULL_TH, DEPTH-2, ALMOST_FULL asserts when level ≥ this; range 1..DEPTH
- ALMOST_EMPTY_TH, 2, ALMOST_EMPTY asserts when level ≤ this; range 0..DEPTH-1

Ports (AW = clog2(DEPTH)):
- CLK  in  1  single clock; all logic on its rising edge
- RST  in  1  synchronous, active-high reset
- W_INC  in  1  write request
- WR_DATA  in  DATA_WIDTH  write word
- R_INC  in  1  read request (pop)
- CLR_ERR  in  1  clears OVERFLOW/UNDERFLOW
- RD_DATA  out  DATA_WIDTH  read word
- RD_VALID  out  1  RD_DATA qualifier
- FULL, EMPTY  out  1 each  occupancy flags
- ALMOST_FULL, ALMOST_EMPTY  out  1 each  threshold flags
- FILL_LEVEL  out  AW+1  entries stored, 0..DEPTH
- OVERFLOW, UNDERFLOW  out  1 each  sticky error flags

## Operation
- Storage is a DEPTH×DATA_WIDTH register array.
- Write and read pointers are AW+1 bits wide; the extra MSB is the wrap bit. Pointers wrap modulo 2·DEPTH.
- Flag decode:
  - EMPTY when the two pointers are equal.
  - FULL when they differ only in the MSB.
  - FILL_LEVEL = wr_ptr − rd_ptr, taken modulo 2^(AW+1).
- Write acceptance: a write is accepted iff W_INC && !FULL. An accepted write stores WR_DATA at mem[wr_ptr[AW-1:0]] and increments wr_ptr.
- Read acceptance: a read is accepted iff R_INC && !EMPTY, and increments rd_ptr.
- Simultaneous write and read:
  - Neither full nor empty: both are accepted and the level is unchanged.
  - EMPTY: only the write is accepted and UNDERFLOW sets.
  - FULL: only the read is accepted and OVERFLOW sets.
- Error flags:
  - OVERFLOW sets on W_INC && FULL.
  - UNDERFLOW sets on R_INC && EMPTY.
  - Both stay set until a CLR_ERR cycle. If set and clear occur in the same cycle, set wins.
- ALMOST_FULL = (FILL_LEVEL ≥ ALMOST_FULL_TH); ALMOST_EMPTY = (FILL_LEVEL ≤ ALMOST_EMPTY_TH).
- Reset:
  - Pointers, RD_DATA, RD_VALID, OVERFLOW and UNDERFLOW go to 0. The memory is not cleared.
  - Resulting outputs: EMPTY=1, ALMOST_EMPTY=1, FULL=0, ALMOST_FULL=0, FILL_LEVEL=0.
  - A reset asserted mid-burst discards all contents. Requests in the reset cycle are ignored and set no error flag.

## Timing
- All flags and FILL_LEVEL decode combinationally from the registered pointers. They therefore reflect an accepted access from the cycle after its clock edge.
- Write-to-read latency: a word written at edge N can be popped by a request at edge N+1 at the earliest (EMPTY drops after edge N).
- Read data timing is set by the build mode (see Configuration).
- No combinational path exists from W_INC/R_INC to any output.

## Configuration
- Macro: SYNC_FIFO_FWFT_EN.
- Undefined (standard mode):
  - An accepted read at edge N registers mem[rd_ptr] into RD_DATA.
  - RD_VALID is high for exactly the cycle after edge N.
  - RD_DATA holds its value when no read is accepted.
- Defined (first-word-fall-through mode):
  - RD_DATA = mem[rd_ptr] combinationally, gated to 0 when EMPTY.
  - RD_VALID = !EMPTY.
  - R_INC acknowledges the word currently shown; the next word (if any) appears after the edge.
  - RD_DATA and RD_VALID are still 0 during and after reset.

## Structure
- Shared package fifo_pkg holds:
  - a constant-function clog2
  - default DATA_WIDTH/DEPTH constants shared with the dual-clock FIFO
- Sub-module sync_fifo_mem: register-array memory with a synchronous write port and an asynchronous read port, parameters DATA_WIDTH and DEPTH. The FWFT and standard paths both read from it.
- The top level holds pointers, flag decode, error flags and the read-output stage.

## Test plan
All cases use DATA_WIDTH=8, DEPTH=8, ALMOST_FULL_TH=6, ALMOST_EMPTY_TH=2.

- **Reset values:** hold RST high for 2 cycles → EMPTY=1, ALMOST_EMPTY=1, FULL=0, FILL_LEVEL=0, RD_VALID=0, RD_DATA=0x00.
- **Write then read:** write 0x83, 0x86, 0x80, 0x84, then read 4.
  - Standard mode: RD_DATA shows 0x83, 0x86, 0x80, 0x84, each with a one-cycle RD_VALID pulse.
  - FWFT mode: 0x83 is visible one cycle after its write.
- **Fill and overflow:** write 9 words (0x01..0x09).
  - ALMOST_FULL rises after the 6th write; FULL and FILL_LEVEL=8 after the 8th.
  - The 9th write is dropped and OVERFLOW=1.
  - Reading 8 words returns 0x01..0x08.
  - CLR_ERR clears OVERFLOW.
- **Underflow when empty:** assert R_INC and W_INC together while EMPTY with WR_DATA=0x55 → write accepted, UNDERFLOW=1, FILL_LEVEL=1; the next read returns 0x55.
- **Wrap-around:** run 20 write/read pairs, with simultaneous W_INC/R_INC at level 3 for 12 cycles.
  - FILL_LEVEL stays 3.
  - Data order is preserved across the pointer wrap.
  - No error flag sets.
- **Reset mid-burst:** assert RST at level 5 while W_INC=1 → next cycle EMPTY=1, FILL_LEVEL=0, error flags 0, and no write occurs in the reset cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO package: constant-function clog2 and default geometry common to
// the single-clock and dual-clock FIFOs.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_DEPTH      = 8;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Register-array storage for sync_fifo: synchronous write port, asynchronous
// read port. Contents are never reset.
module sync_fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [clog2(DEPTH)-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [clog2(DEPTH)-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]     rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fill level, almost-full/empty thresholds and sticky
// overflow/underflow flags. Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH      = FIFO_DATA_WIDTH,
    parameter int DEPTH           = FIFO_DEPTH,
    parameter int ALMOST_FULL_TH  = DEPTH - 2,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    W_INC,
    input  logic [DATA_WIDTH-1:0]   WR_DATA,
    input  logic                    R_INC,
    input  logic                    CLR_ERR,
    output logic [DATA_WIDTH-1:0]   RD_DATA,
    output logic                    RD_VALID,
    output logic                    FULL,
    output logic                    EMPTY,
    output logic                    ALMOST_FULL,
    output logic                    ALMOST_EMPTY,
    output logic [clog2(DEPTH):0]   FILL_LEVEL,
    output logic                    OVERFLOW,
    output logic                    UNDERFLOW
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] AF_TH   = (AW+1)'(ALMOST_FULL_TH);
    localparam logic [AW:0] AE_TH   = (AW+1)'(ALMOST_EMPTY_TH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [AW:0]           fill_level;
    logic                  full;
    logic                  empty;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    // Extra pointer MSB distinguishes full from empty when the addresses match.
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fill_level = wr_ptr - rd_ptr;
    assign wr_acc     = W_INC && !full && !RST;
    assign rd_acc     = R_INC && !empty && !RST;

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (CLK),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (WR_DATA),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (mem_rd_data)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            // A new error in the clearing cycle keeps the flag set.
            OVERFLOW  <= (W_INC && full)  || (OVERFLOW  && !CLR_ERR);
            UNDERFLOW <= (R_INC && empty) || (UNDERFLOW && !CLR_ERR);
        end
    end

    assign FULL         = full;
    assign EMPTY        = empty;
    assign FILL_LEVEL   = fill_level;
    assign ALMOST_FULL  = (fill_level >= AF_TH);
    assign ALMOST_EMPTY = (fill_level <= AE_TH);

`ifdef SYNC_FIFO_FWFT_EN
    assign RD_DATA  = (empty || RST) ? '0 : mem_rd_data;
    assign RD_VALID = !empty && !RST;
`else
    logic [DATA_WIDTH-1:0] rd_data_p1;
    logic                  rd_vld_p1;

    // Stage p1: registered read word, held until the next accepted pop.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_data_p1 <= '0;
            rd_vld_p1  <= 1'b0;
        end else begin
            rd_vld_p1 <= rd_acc;
            if (rd_acc) begin
                rd_data_p1 <= mem_rd_data;
            end
        end
    end

    assign RD_DATA  = rd_data_p1;
    assign RD_VALID = rd_vld_p1;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: queue-based reference model compared every
// cycle, plus directed vectors with hand-computed expectations.
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AFT   = 6;
    localparam int AET   = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          W_INC = 1'b0;
    logic [DW-1:0] WR_DATA = '0;
    logic          R_INC = 1'b0;
    logic          CLR_ERR = 1'b0;
    logic [DW-1:0] RD_DATA;
    logic          RD_VALID;
    logic          FULL;
    logic          EMPTY;
    logic          ALMOST_FULL;
    logic          ALMOST_EMPTY;
    logic [3:0]    FILL_LEVEL;
    logic          OVERFLOW;
    logic          UNDERFLOW;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    sync_fifo #(
        .DATA_WIDTH      (DW),
        .DEPTH           (DEPTH),
        .ALMOST_FULL_TH  (AFT),
        .ALMOST_EMPTY_TH (AET)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .W_INC        (W_INC),
        .WR_DATA      (WR_DATA),
        .R_INC        (R_INC),
        .CLR_ERR      (CLR_ERR),
        .RD_DATA      (RD_DATA),
        .RD_VALID     (RD_VALID),
        .FULL         (FULL),
        .EMPTY        (EMPTY),
        .ALMOST_FULL  (ALMOST_FULL),
        .ALMOST_EMPTY (ALMOST_EMPTY),
        .FILL_LEVEL   (FILL_LEVEL),
        .OVERFLOW     (OVERFLOW),
        .UNDERFLOW    (UNDERFLOW)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored words plus the sticky flags.
    logic [DW-1:0] q[$];
    bit            m_ov = 1'b0;
    bit            m_un = 1'b0;
    logic [DW-1:0] m_rd_data = '0;
    bit            m_rd_valid = 1'b0;

    always @(posedge CLK) begin
        bit is_full;
        bit is_empty;
        bit w_ok;
        bit r_ok;
        if (RST) begin
            q.delete();
            m_ov       = 1'b0;
            m_un       = 1'b0;
            m_rd_data  = '0;
            m_rd_valid = 1'b0;
        end else begin
            is_full  = (q.size() == DEPTH);
            is_empty = (q.size() == 0);
            w_ok     = W_INC && !is_full;
            r_ok     = R_INC && !is_empty;
            m_ov     = (W_INC && is_full)  || (m_ov && !CLR_ERR);
            m_un     = (R_INC && is_empty) || (m_un && !CLR_ERR);
            m_rd_valid = r_ok;
            if (r_ok) m_rd_data = q.pop_front();
            if (w_ok) q.push_back(WR_DATA);
        end
    end

    always @(posedge CLK) begin
        #1;
        if (chk_en) begin
            check("m_empty", 32'(EMPTY), 32'(q.size() == 0));
            check("m_full", 32'(FULL), 32'(q.size() == DEPTH));
            check("m_level", 32'(FILL_LEVEL), 32'(q.size()));
            check("m_afull", 32'(ALMOST_FULL), 32'(q.size() >= AFT));
            check("m_aempty", 32'(ALMOST_EMPTY), 32'(q.size() <= AET));
            check("m_ovf", 32'(OVERFLOW), 32'(m_ov));
            check("m_unf", 32'(UNDERFLOW), 32'(m_un));
`ifdef SYNC_FIFO_FWFT_EN
            check("m_rd_valid", 32'(RD_VALID), 32'(q.size() != 0));
            check("m_rd_data", 32'(RD_DATA), 32'((q.size() != 0) ? q[0] : 8'h00));
`else
            check("m_rd_valid", 32'(RD_VALID), 32'(m_rd_valid));
            check("m_rd_data", 32'(RD_DATA), 32'(m_rd_data));
`endif
        end
    end

    // Called at a falling edge; applies inputs across one rising edge.
    task automatic step(input bit w, input logic [7:0] d, input bit r, input bit clr);
        W_INC   = w;
        WR_DATA = d;
        R_INC   = r;
        CLR_ERR = clr;
        @(negedge CLK);
        W_INC   = 1'b0;
        R_INC   = 1'b0;
        CLR_ERR = 1'b0;
    endtask

    task automatic pop_expect(input bit w, input logic [7:0] d, input logic [7:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
        check("pop_valid", 32'(RD_VALID), 32'h1);
        check("pop_data", 32'(RD_DATA), 32'(exp));
        step(w, d, 1'b1, 1'b0);
`else
        step(w, d, 1'b1, 1'b0);
        check("pop_valid", 32'(RD_VALID), 32'h1);
        check("pop_data", 32'(RD_DATA), 32'(exp));
`endif
    endtask

    logic [7:0] wr_vec [4];

    initial begin
        wr_vec[0] = 8'h83; wr_vec[1] = 8'h86; wr_vec[2] = 8'h80; wr_vec[3] = 8'h84;
        @(negedge CLK);
        // Reset values
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk_en = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("rst_empty", 32'(EMPTY), 32'h1);
        check("rst_aempty", 32'(ALMOST_EMPTY), 32'h1);
        check("rst_full", 32'(FULL), 32'h0);
        check("rst_afull", 32'(ALMOST_FULL), 32'h0);
        check("rst_level", 32'(FILL_LEVEL), 32'h0);
        check("rst_valid", 32'(RD_VALID), 32'h0);
        check("rst_data", 32'(RD_DATA), 32'h0);
        check("rst_ovf", 32'(OVERFLOW), 32'h0);
        RST = 1'b0;

        // Write then read
        step(1'b1, wr_vec[0], 1'b0, 1'b0);
        check("wr1_empty", 32'(EMPTY), 32'h0);
`ifdef SYNC_FIFO_FWFT_EN
        check("fwft_first", 32'(RD_DATA), 32'h83);
`endif
        for (int i = 1; i < 4; i++) step(1'b1, wr_vec[i], 1'b0, 1'b0);
        check("wr4_level", 32'(FILL_LEVEL), 32'h4);
        for (int i = 0; i < 4; i++) pop_expect(1'b0, 8'h00, wr_vec[i]);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("idle_valid", 32'(RD_VALID), 32'h0);
`ifndef SYNC_FIFO_FWFT_EN
        check("hold_data", 32'(RD_DATA), 32'h84);
`endif

        // Fill and overflow
        for (int i = 1; i <= 9; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 5) check("af_at5", 32'(ALMOST_FULL), 32'h0);
            if (i == 6) check("af_at6", 32'(ALMOST_FULL), 32'h1);
            if (i == 7) check("full_at7", 32'(FULL), 32'h0);
            if (i == 8) begin
                check("full_at8", 32'(FULL), 32'h1);
                check("level_at8", 32'(FILL_LEVEL), 32'h8);
                check("ovf_at8", 32'(OVERFLOW), 32'h0);
            end
        end
        check("ovf_set", 32'(OVERFLOW), 32'h1);
        check("level_ovf", 32'(FILL_LEVEL), 32'h8);
        for (int i = 1; i <= 8; i++) pop_expect(1'b0, 8'h00, 8'(i));
        check("drain_empty", 32'(EMPTY), 32'h1);
        check("ovf_sticky", 32'(OVERFLOW), 32'h1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_clr", 32'(OVERFLOW), 32'h0);

        // Underflow when empty, with a simultaneous write
        step(1'b1, 8'h55, 1'b1, 1'b0);
        check("unf_set", 32'(UNDERFLOW), 32'h1);
        check("unf_level", 32'(FILL_LEVEL), 32'h1);
        pop_expect(1'b0, 8'h00, 8'h55);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        check("unf_set_wins", 32'(UNDERFLOW), 32'h1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("unf_clr", 32'(UNDERFLOW), 32'h0);

        // Wrap-around at steady level 3
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            pop_expect(1'b1, 8'(8'hA3 + i), 8'(8'hA0 + i));
            check("wrap_level", 32'(FILL_LEVEL), 32'h3);
        end
        for (int i = 12; i < 15; i++) pop_expect(1'b0, 8'h00, 8'(8'hA0 + i));
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
            pop_expect(1'b0, 8'h00, 8'(8'hC0 + i));
        end
        check("wrap_ovf", 32'(OVERFLOW), 32'h0);
        check("wrap_unf", 32'(UNDERFLOW), 32'h0);

        // Reset mid-burst
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("pre_unf", 32'(UNDERFLOW), 32'h1);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        check("pre_level", 32'(FILL_LEVEL), 32'h5);
        RST = 1'b1;
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        check("mrst_empty", 32'(EMPTY), 32'h1);
        check("mrst_level", 32'(FILL_LEVEL), 32'h0);
        check("mrst_unf", 32'(UNDERFLOW), 32'h0);
        check("mrst_ovf", 32'(OVERFLOW), 32'h0);
        check("mrst_valid", 32'(RD_VALID), 32'h0);
        RST = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("post_empty", 32'(EMPTY), 32'h1);
        check("post_level", 32'(FILL_LEVEL), 32'h0);
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        pop_expect(1'b0, 8'h00, 8'h3C);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
